// File: rtl/denise_sprite_if.sv
// Chip-bus / mixer side signals of the Denise sprite engine.
// SPR_COLLISION_EN adds the collision read strobe and sticky collision bits.
interface denise_sprite_if #(
  parameter int NSPR = 8
);
  logic            clk7_en;
  logic            shift_en;
  logic            aga;
  logic [8:1]      reg_address_in;
  logic [15:0]     data_in;
  logic [47:0]     chip48;
  logic [8:0]      hpos;
  logic            sprena;
  logic [3:0]      esprm;
  logic [3:0]      osprm;
  logic [NSPR-1:0] nsprite;
  logic [7:0]      sprdata;

`ifdef SPR_COLLISION_EN
  localparam int NPAIR = NSPR / 2;
  localparam int NCOLL = (NPAIR > 1) ? NPAIR * (NPAIR - 1) / 2 : 1;

  logic             coll_rd;
  logic [NCOLL-1:0] sprcoll;

  modport master (
    output clk7_en, shift_en, aga, reg_address_in, data_in, chip48,
    output hpos, sprena, esprm, osprm, coll_rd,
    input  nsprite, sprdata, sprcoll
  );
  modport slave (
    input  clk7_en, shift_en, aga, reg_address_in, data_in, chip48,
    input  hpos, sprena, esprm, osprm, coll_rd,
    output nsprite, sprdata, sprcoll
  );
`else
  modport master (
    output clk7_en, shift_en, aga, reg_address_in, data_in, chip48,
    output hpos, sprena, esprm, osprm,
    input  nsprite, sprdata
  );
  modport slave (
    input  clk7_en, shift_en, aga, reg_address_in, data_in, chip48,
    input  hpos, sprena, esprm, osprm,
    output nsprite, sprdata
  );
`endif
endinterface

// File: rtl/denise_sprite_engine.sv
// Denise sprite unit: NSPR per-channel arm/trigger/shift sequencers and a registered pair
// priority/attach colour mux. Optional feature macro: SPR_COLLISION_EN (sticky pair collisions).
module denise_sprite_engine #(
  parameter int         NSPR      = 8,
  parameter logic [8:0] BASE      = 9'h140,
  parameter logic [8:0] FMODE_ADR = 9'h1FC,
  parameter int         MAXW      = 64
) (
  input  logic           clk,
  input  logic           reset,
  denise_sprite_if.slave bus
);
  localparam int NPAIR = NSPR / 2;

  localparam logic [1:0] S_DISARMED = 2'd0;
  localparam logic [1:0] S_ARMED    = 2'd1;
  localparam logic [1:0] S_SHIFTING = 2'd2;

  function automatic logic [8:0] reg_adr(input int n, input int off);
    return BASE + 9'(8 * n + off);
  endfunction

  // FMODE width code saturated to the widest word this build supports.
  function automatic logic [6:0] sat_width(input logic [1:0] fm, input logic aga);
    logic [6:0] w;
    w = !aga ? 7'd16 : (fm == 2'b00) ? 7'd16 : (fm == 2'b11) ? 7'd64 : 7'd32;
    return (w > 7'(MAXW)) ? 7'(MAXW) : w;
  endfunction

  logic [1:0]       r_fmode;
  logic [1:0]       r_state  [NSPR];
  logic [8:0]       r_hstart [NSPR];
  logic [NSPR-1:0]  r_attach;
  logic [MAXW-1:0]  r_hold_a [NSPR];
  logic [MAXW-1:0]  r_hold_b [NSPR];
  logic [MAXW-1:0]  r_shf_a  [NSPR];
  logic [MAXW-1:0]  r_shf_b  [NSPR];
  logic [6:0]       r_cnt    [NSPR];
  logic [NSPR-1:0]  r_nsprite_p1;
  logic [7:0]       r_sprdata_p1;

  logic [8:0]       w_adr;
  logic             w_fmode_wr;
  logic [6:0]       w_width;
  logic [63:0]      w_bus_word;
  logic [MAXW-1:0]  w_word_p0;
  logic [NSPR-1:0]  w_pos_wr, w_ctl_wr, w_data_wr, w_datb_wr, w_trig;
  logic [1:0]       w_pair_p0 [NSPR];
  logic [NSPR-1:0]  w_opq_p0;
  logic [NPAIR-1:0] w_popq_p0;
  logic [7:0]       w_sprdata_p0;

  assign w_adr      = {bus.reg_address_in, 1'b0};
  assign w_fmode_wr = bus.clk7_en && bus.aga && (w_adr == FMODE_ADR);
  assign w_width    = sat_width(r_fmode, bus.aga);
  assign w_bus_word = {bus.data_in, bus.chip48};
  // Keep only the top W bits of the fetched word, MSB-aligned in the holding register.
  assign w_word_p0  = w_bus_word[63 -: MAXW] & ~({MAXW{1'b1}} >> w_width);

  // ---- stage p0: register decode, trigger compare, per-channel pixel pair ----
  always_comb begin
    for (int n = 0; n < NSPR; n++) begin
      w_pos_wr[n]  = bus.clk7_en && (w_adr == reg_adr(n, 0));
      w_ctl_wr[n]  = bus.clk7_en && (w_adr == reg_adr(n, 2));
      w_data_wr[n] = bus.clk7_en && (w_adr == reg_adr(n, 4));
      w_datb_wr[n] = bus.clk7_en && (w_adr == reg_adr(n, 6));
      w_trig[n]    = bus.clk7_en && (bus.hpos == r_hstart[n]) &&
                     ((r_state[n] == S_ARMED) || (r_state[n] == S_SHIFTING));
      w_pair_p0[n] = ((r_state[n] == S_SHIFTING) && (r_cnt[n] != 7'd0)) ?
                     {r_shf_b[n][MAXW-1], r_shf_a[n][MAXW-1]} : 2'b00;
      w_opq_p0[n]  = bus.sprena && (w_pair_p0[n] != 2'b00);
    end
    for (int k = 0; k < NPAIR; k++) begin
      w_popq_p0[k] = w_opq_p0[2*k] | w_opq_p0[2*k+1];
    end
  end

  always_comb begin
    w_sprdata_p0 = 8'h00;
    for (int k = NPAIR - 1; k >= 0; k--) begin
      if (w_popq_p0[k]) begin
        if (r_attach[2*k+1] || (!bus.aga && r_attach[2*k]))
          w_sprdata_p0 = {bus.osprm, w_pair_p0[2*k+1], w_pair_p0[2*k]};
        else if (w_opq_p0[2*k])
          w_sprdata_p0 = {bus.esprm, 2'(k), w_pair_p0[2*k]};
        else
          w_sprdata_p0 = {bus.osprm, 2'(k), w_pair_p0[2*k+1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fmode  <= 2'b00;
      r_attach <= '0;
      for (int n = 0; n < NSPR; n++) begin
        r_state[n]  <= S_DISARMED;
        r_hstart[n] <= '0;
        r_hold_a[n] <= '0;
        r_hold_b[n] <= '0;
        r_shf_a[n]  <= '0;
        r_shf_b[n]  <= '0;
        r_cnt[n]    <= '0;
      end
    end else begin
      if (w_fmode_wr) r_fmode <= bus.data_in[3:2];
      for (int n = 0; n < NSPR; n++) begin
        if (w_pos_wr[n]) r_hstart[n][8:1] <= bus.data_in[7:0];
        if (w_ctl_wr[n]) begin
          r_hstart[n][0] <= bus.data_in[0];
          r_attach[n]    <= bus.data_in[7];
        end
        if (w_data_wr[n]) r_hold_a[n] <= w_word_p0;
        if (w_datb_wr[n]) r_hold_b[n] <= w_word_p0;

        if (w_ctl_wr[n]) begin
          r_state[n] <= S_DISARMED;
          r_cnt[n]   <= '0;
        end else if (w_trig[n]) begin
          r_shf_a[n] <= r_hold_a[n];
          r_shf_b[n] <= r_hold_b[n];
          r_cnt[n]   <= w_width;
          r_state[n] <= S_SHIFTING;
        end else if ((r_state[n] == S_SHIFTING) && bus.shift_en && (r_cnt[n] != 7'd0)) begin
          r_shf_a[n] <= {r_shf_a[n][MAXW-2:0], 1'b0};
          r_shf_b[n] <= {r_shf_b[n][MAXW-2:0], 1'b0};
          r_cnt[n]   <= r_cnt[n] - 7'd1;
          // Last pixel leaves the channel armed so the next line can re-trigger it.
          if (r_cnt[n] == 7'd1) r_state[n] <= S_ARMED;
        end else if (w_data_wr[n] && (r_state[n] == S_DISARMED)) begin
          r_state[n] <= S_ARMED;
        end
      end
    end
  end

  // ---- stage p1: registered colour index and opaque flags ----
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sprdata_p1 <= 8'h00;
      r_nsprite_p1 <= '0;
    end else begin
      r_sprdata_p1 <= w_sprdata_p0;
      r_nsprite_p1 <= w_opq_p0;
    end
  end

  assign bus.sprdata = r_sprdata_p1;
  assign bus.nsprite = r_nsprite_p1;

`ifdef SPR_COLLISION_EN
  localparam int NCOLL = (NPAIR > 1) ? NPAIR * (NPAIR - 1) / 2 : 1;

  function automatic int coll_idx(input int i, input int j);
    return i * (2 * NPAIR - i - 1) / 2 + (j - i - 1);
  endfunction

  logic             r_coll_rd_p1;
  logic [NCOLL-1:0] r_coll;
  logic [NCOLL-1:0] w_coll_set;

  always_comb begin
    w_coll_set = '0;
    for (int i = 0; i < NPAIR; i++)
      for (int j = i + 1; j < NPAIR; j++)
        w_coll_set[coll_idx(i, j)] = w_popq_p0[i] & w_popq_p0[j];
  end

  // A clear lands one clock after the read strobe; a simultaneous set wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_coll_rd_p1 <= 1'b0;
      r_coll       <= '0;
    end else begin
      r_coll_rd_p1 <= bus.coll_rd;
      r_coll       <= (r_coll & ~{NCOLL{r_coll_rd_p1}}) | w_coll_set;
    end
  end

  assign bus.sprcoll = r_coll;
`endif

endmodule

// File: tb/tb_denise_sprite_engine.sv
// Directed bench for denise_sprite_engine: table-driven priority/attach vectors plus
// hand-written sequences for trigger timing, fetch width, disarm and reset.
module tb_denise_sprite_engine;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  denise_sprite_if #(.NSPR(8)) bus ();
  denise_sprite_engine #(.NSPR(8)) dut (.clk(clk), .reset(reset), .bus(bus));

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] attach;
    logic       aga;
    logic       sprena;
    logic [3:0] esprm;
    logic [3:0] osprm;
    logic [7:0] exp_spr;
    logic [7:0] exp_nspr;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [8:0] radr(input int n, input int off);
    return 9'h140 + 9'(8 * n + off);
  endfunction

  task automatic wr(input logic [8:0] adr, input logic [15:0] d, input logic [47:0] c48);
    bus.reg_address_in = adr[8:1];
    bus.data_in        = d;
    bus.chip48         = c48;
    tick();
    bus.reg_address_in = 8'hFF;
    bus.data_in        = 16'h0000;
    bus.chip48         = 48'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic trigger(input logic [8:0] hp);
    bus.hpos = hp;
    tick();
    bus.hpos = 9'h000;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    bus.aga    = v.aga;
    bus.sprena = v.sprena;
    bus.esprm  = v.esprm;
    bus.osprm  = v.osprm;
    for (int n = 0; n < 8; n++) begin
      wr(radr(n, 0), 16'h0080, 48'h0);
      wr(radr(n, 2), {8'h00, v.attach[n], 7'h00}, 48'h0);
      wr(radr(n, 6), v.b[n] ? 16'h8000 : 16'h0000, 48'h0);
      wr(radr(n, 4), v.a[n] ? 16'h8000 : 16'h0000, 48'h0);
    end
    trigger(9'h100);
    tick();
    check($sformatf("vec%0d_sprdata", idx), {24'h0, bus.sprdata}, {24'h0, v.exp_spr});
    check($sformatf("vec%0d_nsprite", idx), {24'h0, bus.nsprite}, {24'h0, v.exp_nspr});
  endtask

  // One triggered run of channel 2: opaque pixel expected on tick i when exp_mask says so.
  task automatic run_ch2(input string nm, input int lo, input int hi, input int extra);
    trigger(9'h080);
    for (int i = 1; i <= 66; i++) begin
      logic [7:0] e;
      tick();
      e = (((i >= lo) && (i <= hi)) || (i == extra)) ? 8'h05 : 8'h00;
      check($sformatf("%s_t%0d", nm, i), {24'h0, bus.sprdata}, {24'h0, e});
    end
  endtask

  initial begin
    //               a      b      attach aga sprena esprm osprm  spr    nspr
    vecs[0] = '{8'h10, 8'h20, 8'h20, 1'b1, 1'b1, 4'h5, 4'h3, 8'h39, 8'h30};
    vecs[1] = '{8'h10, 8'h20, 8'h00, 1'b1, 1'b1, 4'h5, 4'h3, 8'h59, 8'h30};
    vecs[2] = '{8'h42, 8'h02, 8'h00, 1'b1, 1'b1, 4'h1, 4'h2, 8'h23, 8'h42};
    vecs[3] = '{8'h42, 8'h02, 8'h00, 1'b1, 1'b0, 4'h1, 4'h2, 8'h00, 8'h00};
    vecs[4] = '{8'h80, 8'h40, 8'h00, 1'b1, 1'b1, 4'h1, 4'h2, 8'h1E, 8'hC0};
    vecs[5] = '{8'h10, 8'h20, 8'h10, 1'b0, 1'b1, 4'h5, 4'h3, 8'h39, 8'h30};
    vecs[6] = '{8'h10, 8'h20, 8'h10, 1'b1, 1'b1, 4'h5, 4'h3, 8'h59, 8'h30};
    vecs[7] = '{8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 4'h5, 4'h3, 8'h00, 8'h00};
    vecs[8] = '{8'h05, 8'h01, 8'h02, 1'b1, 1'b1, 4'h5, 4'hA, 8'hA3, 8'h05};

    reset              = 1'b1;
    bus.clk7_en        = 1'b1;
    bus.shift_en       = 1'b1;
    bus.aga            = 1'b0;
    bus.reg_address_in = 8'hFF;
    bus.data_in        = 16'h0000;
    bus.chip48         = 48'h0;
    bus.hpos           = 9'h000;
    bus.sprena         = 1'b1;
    bus.esprm          = 4'h0;
    bus.osprm          = 4'h0;
`ifdef SPR_COLLISION_EN
    bus.coll_rd        = 1'b0;
`endif
    do_reset();
    check("reset_sprdata", {24'h0, bus.sprdata}, 32'h0);
    check("reset_nsprite", {24'h0, bus.nsprite}, 32'h0);

    // Channel 0, pattern 8001, hpos sweeping through the start position 0x80.
    wr(radr(0, 0), 16'h0040, 48'h0);
    wr(radr(0, 2), 16'h0000, 48'h0);
    wr(radr(0, 6), 16'h0000, 48'h0);
    wr(radr(0, 4), 16'h8001, 48'h0);
    for (int i = 0; i < 22; i++) begin
      logic [7:0] e;
      bus.hpos = 9'h07C + 9'(i);
      tick();
      e = (i == 5 || i == 20) ? 8'h01 : 8'h00;
      check($sformatf("sweep_spr_%0d", i), {24'h0, bus.sprdata}, {24'h0, e});
      check($sformatf("sweep_nspr_%0d", i), {24'h0, bus.nsprite}, {24'h0, 7'h0, e[0]});
    end
    bus.hpos = 9'h000;

    for (int v = 0; v < 9; v++) apply_vec(vecs[v], v);

    // Fetch width: FMODE ignored without AGA, then 16 opaque + 48 transparent at width 64.
    do_reset();
    bus.aga = 1'b0;
    bus.sprena = 1'b1;
    bus.esprm = 4'h0;
    bus.osprm = 4'h0;
    wr(9'h1FC, 16'h000C, 48'h0);
    bus.aga = 1'b1;
    wr(radr(2, 0), 16'h0040, 48'h0);
    wr(radr(2, 2), 16'h0000, 48'h0);
    wr(radr(2, 6), 16'h0000, 48'h0);
    wr(radr(2, 4), 16'h8000, 48'h1);
    run_ch2("w16", 1, 1, 0);
    wr(9'h1FC, 16'h000C, 48'h0);
    wr(radr(2, 4), 16'hFFFF, 48'h0);
    run_ch2("w64ff", 1, 16, 0);
    wr(radr(2, 4), 16'h8000, 48'h1);
    run_ch2("w64ends", 1, 1, 64);
    trigger(9'h080);
    tick();
    check("w64_rearm", {24'h0, bus.sprdata}, 32'h05);

    // CTL write mid-shift stops pixels; DATA rewrite alone does not trigger.
    do_reset();
    bus.aga = 1'b0;
    wr(radr(0, 0), 16'h0040, 48'h0);
    wr(radr(0, 2), 16'h0000, 48'h0);
    wr(radr(0, 6), 16'h0000, 48'h0);
    wr(radr(0, 4), 16'hFFFF, 48'h0);
    trigger(9'h080);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("ctl_pre_%0d", i), {24'h0, bus.sprdata}, 32'h01);
    end
    wr(radr(0, 2), 16'h0000, 48'h0);
    check("ctl_edge", {24'h0, bus.sprdata}, 32'h01);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("ctl_post_%0d", i), {24'h0, bus.sprdata}, 32'h00);
    end
    wr(radr(0, 4), 16'hFFFF, 48'h0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("nomatch_%0d", i), {24'h0, bus.sprdata}, 32'h00);
    end
    trigger(9'h080);
    tick();
    check("rearm_pixel", {24'h0, bus.sprdata}, 32'h01);

    // Reset mid-shift clears outputs and leaves every channel disarmed.
    tick();
    check("rst_pre", {24'h0, bus.sprdata}, 32'h01);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_sprdata", {24'h0, bus.sprdata}, 32'h00);
    check("rst_nsprite", {24'h0, bus.nsprite}, 32'h00);
    for (int i = 0; i < 6; i++) begin
      bus.hpos = (i < 3) ? 9'(i) : 9'h07F + 9'(i - 3);
      tick();
      check($sformatf("rst_notrig_%0d", i), {24'h0, bus.sprdata}, 32'h00);
    end
    tick();
    check("rst_notrig_last", {24'h0, bus.nsprite}, 32'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
